// File: rtl/bit_unstuffer.sv
// Receive-side bit unstuffer: drops the stuffed 0 after MAX_RUN consecutive 1s,
// flags stuff errors, and tracks packet framing and the delivered-bit count.
module bit_unstuffer #(
  parameter int MAX_RUN = 6,
  parameter int CNT_W   = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bstr_in,
  input  logic             bstr_in_valid,
  input  logic             pkt_start,
  input  logic             pkt_end,
  output logic             bstr_out,
  output logic             bstr_out_valid,
  output logic             stuff_err,
  output logic             pkt_done,
  output logic [CNT_W-1:0] bit_count,
  output logic             busy
);

  // state | meaning
  // IDLE  | waiting for a bit flagged pkt_start; other bits are dropped
  // RECV  | inside a packet, delivering bits and removing stuffed 0s
  // ERR   | stuff error seen; discard bits until pkt_end or a new pkt_start
  typedef enum logic [1:0] {IDLE, RECV, ERR} state_t;

  localparam logic [2:0] RUN_MAX = 3'(MAX_RUN);

  state_t           state_q, state_d;
  logic [2:0]       run_q, run_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             vld_q, vld_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  logic [2:0]       run_base;
  logic [CNT_W-1:0] cnt_base;
  logic             take;

  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    vld_d    = 1'b0;
    err_d    = 1'b0;
    done_d   = 1'b0;
    run_base = run_q;
    cnt_base = cnt_q;
    take     = 1'b0;

    if (bstr_in_valid) begin
      // pkt_start always wins: it aborts RECV or ERR and restarts the packet
      if (pkt_start) begin
        take     = 1'b1;
        run_base = 3'd0;
        cnt_base = '0;
      end else if (state_q == RECV) begin
        take = 1'b1;
      end else if (state_q == ERR && pkt_end) begin
        state_d = IDLE;
      end

      if (take) begin
        state_d = RECV;
        run_d   = run_base;
        cnt_d   = cnt_base;
        if (run_base < RUN_MAX) begin
          vld_d = 1'b1;
          out_d = bstr_in;
          run_d = bstr_in ? run_base + 3'd1 : 3'd0;
          if (cnt_base != '1) cnt_d = cnt_base + 1'b1;
        end else if (!bstr_in) begin
          run_d = 3'd0;
        end else begin
          err_d   = 1'b1;
          run_d   = 3'd0;
          state_d = ERR;
        end
        if (pkt_end) begin
          state_d = IDLE;
          done_d  = ~err_d;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      run_q   <= 3'd0;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign bstr_out       = out_q;
  assign bstr_out_valid = vld_q;
  assign stuff_err      = err_q;
  assign pkt_done       = done_q;
  assign bit_count      = cnt_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_bit_unstuffer.sv
// Bench for bit_unstuffer: directed packets plus random traffic, every cycle
// compared against a packet-level reference model.
module tb_bit_unstuffer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       bstr_in = 1'b0;
  logic       bstr_in_valid = 1'b0;
  logic       pkt_start = 1'b0;
  logic       pkt_end = 1'b0;
  logic       bstr_out, bstr_out_valid, stuff_err, pkt_done, busy;
  logic [6:0] bit_count;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: packet phase, trailing ones since last removal, delivered count
  bit in_packet, discarding;
  int ones_seen, delivered;
  bit e_out, e_vld, e_err, e_done;

  always #5 clk = ~clk;

  bit_unstuffer dut (
    .clk(clk), .rst(rst), .bstr_in(bstr_in), .bstr_in_valid(bstr_in_valid),
    .pkt_start(pkt_start), .pkt_end(pkt_end), .bstr_out(bstr_out),
    .bstr_out_valid(bstr_out_valid), .stuff_err(stuff_err), .pkt_done(pkt_done),
    .bit_count(bit_count), .busy(busy)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_update();
    e_vld = 0; e_err = 0; e_done = 0;
    if (rst) begin
      in_packet = 0; discarding = 0; ones_seen = 0; delivered = 0; e_out = 0;
    end else if (bstr_in_valid) begin
      if (pkt_start) begin
        in_packet = 1; discarding = 0; ones_seen = 0; delivered = 0;
      end
      if (in_packet) begin
        if (ones_seen == 6) begin
          ones_seen = 0;
          if (bstr_in) begin
            e_err = 1; in_packet = 0; discarding = 1;
          end
        end else begin
          e_vld = 1; e_out = bstr_in;
          ones_seen = bstr_in ? ones_seen + 1 : 0;
          if (delivered < 127) delivered++;
        end
        if (pkt_end) begin
          e_done = !e_err; in_packet = 0; discarding = 0;
        end
      end else if (discarding && pkt_end) begin
        discarding = 0;
      end
    end
  endtask

  task automatic check_outputs();
    chk("valid", bstr_out_valid, e_vld);
    if (e_vld || rst) chk("data", bstr_out, e_out);
    chk("stuff_err", stuff_err, e_err);
    chk("pkt_done", pkt_done, e_done);
    chk("bit_count", bit_count, delivered);
    chk("busy", busy, in_packet || discarding);
  endtask

  task automatic step(input bit r, input bit v, input bit b, input bit s, input bit e);
    rst = r; bstr_in_valid = v; bstr_in = b; pkt_start = s; pkt_end = e;
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic send(input bit b, input bit s, input bit e);
    step(0, 1, b, s, e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    bit [8:0] p1;
    bit in_gen;
    int gen_ones;
    bit r, v, b, s, e;

    @(negedge clk);
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 0);

    // 1: 0,1x6,stuffed 0,1
    p1 = 9'b1_0111111_0;
    for (int i = 0; i < 9; i++) send(p1[i], i == 0, i == 8);
    chk("t1_count", bit_count, 8);
    idle(2);

    // 2: stuff error then discard until pkt_end
    for (int i = 0; i < 7; i++) send(1, i == 0, 0);
    send(0, 0, 0);
    send(1, 0, 0);
    send(1, 0, 1);
    idle(2);

    // 3: 12 ones with two stuffed zeros, the last carrying pkt_end
    for (int i = 0; i < 6; i++) send(1, i == 0, 0);
    send(0, 0, 0);
    for (int i = 0; i < 6; i++) send(1, 0, 0);
    send(0, 0, 1);
    chk("t3_count", bit_count, 12);
    idle(1);

    // 4: gapped run
    for (int i = 0; i < 6; i++) begin
      send(1, i == 0, 0);
      idle(2);
    end
    send(0, 0, 0);
    idle(2);
    send(1, 0, 1);
    idle(1);

    // 5: restart mid-packet after five ones
    for (int i = 0; i < 5; i++) send(1, i == 0, 0);
    send(1, 1, 0);
    send(1, 0, 0);
    send(1, 0, 1);
    chk("t5_count", bit_count, 3);
    idle(1);

    // 6: reset mid-packet, then a two-bit packet
    for (int i = 0; i < 5; i++) send(1, i == 0, 0);
    step(1, 1, 1, 0, 0);
    send(1, 1, 0);
    send(1, 0, 1);
    chk("t6_count", bit_count, 2);
    idle(1);

    // single-bit packet and saturation
    send(1, 1, 1);
    for (int i = 0; i < 140; i++) send(i[0], i == 0, i == 139);
    chk("sat_count", bit_count, 127);
    idle(1);

    // random traffic
    in_gen = 0; gen_ones = 0;
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom % 600) == 0;
      v = ($urandom % 4) != 0;
      s = (!in_gen && ($urandom % 4) == 0) || ($urandom % 60) == 0;
      if (gen_ones == 6) b = ($urandom % 8) == 0;
      else b = ($urandom % 4) != 0;
      e = ($urandom % 25) == 0;
      step(r, v, b, s, e);
      if (r) begin
        in_gen = 0; gen_ones = 0;
      end else if (v) begin
        if (s) begin in_gen = 1; gen_ones = 0; end
        gen_ones = (b && gen_ones < 6) ? gen_ones + 1 : 0;
        if (e) in_gen = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bit_unstuffer.md
Name: bit_unstuffer

Overview:
Receive-side counterpart of the USB transmit bit stuffer. Consumes the serial NRZI-decoded bitstream and removes every stuffed 0 that follows six consecutive 1s. Flags a stuff error when the bit after six 1s is a 1. Tracks packet framing and delivered-bit count, and sits between the NRZI decoder and the receive shift/deserialiser.

Parameters:
MAX_RUN, 6, number of consecutive 1s after which the next bit is a stuffed bit.
CNT_W, 7, width of the delivered-bit counter; saturates at 2^CNT_W-1.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
bstr_in  input  1  incoming stuffed bit.
bstr_in_valid  input  1  bstr_in is valid this cycle; at most one bit per cycle.
pkt_start  input  1  qualifies with bstr_in_valid: this bit is the first bit of a packet.
pkt_end  input  1  qualifies with bstr_in_valid: this bit is the last bit of a packet.
bstr_out  output  1  unstuffed data bit.
bstr_out_valid  output  1  bstr_out valid, one-cycle pulse per delivered bit.
stuff_err  output  1  one-cycle pulse: a 1 was received where a stuffed 0 was required.
pkt_done  output  1  one-cycle pulse: packet ended cleanly (no stuff error).
bit_count  output  CNT_W  delivered bits in current/last packet; held after pkt_done until next pkt_start.
busy  output  1  high in RECV or ERR.

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset: the cycle after rst is sampled high, all outputs are 0, state is IDLE, and the ones-run counter (run, 3 bits) is 0. Reset wins over every other input.
- Output registering: all outputs are registered. Fixed latency of 1 cycle from an accepted input bit to bstr_out/bstr_out_valid/stuff_err/pkt_done.
- Inputs without valid: pkt_start and pkt_end are ignored when bstr_in_valid=0. Cycles with bstr_in_valid=0 change nothing except clearing the pulse outputs.
- IDLE:
  - Valid bits without pkt_start are dropped and produce no outputs.
  - A valid bit with pkt_start: bit_count <= 0, run <= 0, state <= RECV, and the bit is processed as in RECV in the same cycle.
- RECV, per valid bit:
  - If run < MAX_RUN: deliver the bit (bstr_out_valid=1, bstr_out=bit). run <= bit ? run+1 : 0. bit_count <= bit_count+1, saturating at all-ones.
  - If run == MAX_RUN and bit=0: this is the stuffed bit. Drop it (no valid) and set run <= 0.
  - If run == MAX_RUN and bit=1: stuff_err=1, no valid, run <= 0, state <= ERR.
- pkt_end in RECV: the bit is processed as above, then state <= IDLE. pkt_done=1 unless that same bit raised stuff_err, in which case only stuff_err pulses and state <= IDLE.
- ERR:
  - All valid bits are discarded with no outputs.
  - pkt_end → IDLE, with no pkt_done.
  - pkt_start → restart as from IDLE.
- pkt_start while RECV: abort the current packet with no pkt_done. Restart with bit_count=0 and run=0, then process the bit as the first bit.
- pkt_start and pkt_end on the same bit: single-bit packet. The bit is delivered and pkt_done pulses in the same output cycle, with bit_count=1.
- Run boundaries: run never exceeds MAX_RUN. A dropped stuffed 0 followed by 1s starts a fresh count. A stuffed 0 that is also the pkt_end bit is dropped and pkt_done still pulses.
- bit_count timing: bit_count is updated together with the corresponding bstr_out_valid, so it is valid in the same cycle as pkt_done.
- busy: 1 in RECV/ERR, 0 in IDLE. It reflects the registered state.

Test Plan:
1. Reset, then packet 0,1,1,1,1,1,1,0(stuffed),1 with pkt_start on first and pkt_end on last → 8 valid outputs 0,1,1,1,1,1,1,1; the stuffed 0 is absent; pkt_done=1, bit_count=8, stuff_err never asserts.
2. Packet of six 1s then 1 → 6 valid 1s, then stuff_err pulse 1 cycle later, state ERR. Further bits give no output. pkt_end → IDLE with no pkt_done; busy falls.
3. Stream of 12 ones with stuffed 0s after the 6th and 12th bits, where the final stuffed 0 carries pkt_end → 12 outputs, both 0s dropped, pkt_done=1, bit_count=12.
4. Gapped input with bstr_in_valid toggling 1,0,0,1 around a 6-ones run → run count preserved across gaps; stuffed 0 is dropped correctly; each output lags its input by exactly 1 cycle.
5. pkt_start mid-packet after 5 ones, followed by 1,1 with pkt_end → no pkt_done for the aborted packet; new packet delivers 3 ones (run restarted), bit_count=3.
6. rst asserted mid-packet with run=5 → next cycle all outputs 0, IDLE. A subsequent packet 1,1 with start/end gives bit_count=2 and no false stuff_err.
